// File: rtl/barrel_shift_pkg.sv
// ============================================================================
// Module  : barrel_shift_pkg
// Brief   : Shift-op encoding and single-level shift helpers for the barrel shifter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package barrel_shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_op_t;

    localparam int c_MAX_W = 64;

    typedef logic [c_MAX_W-1:0] wide_t;

    // One shift level by s on the low w bits of d; bits above w are ignored and returned zero.
    function automatic wide_t shift_level(input wide_t d, input shift_op_t op,
                                          input int w, input int s);
        wide_t mask;
        wide_t din;
        wide_t fill;
        wide_t res;
        mask = ~({c_MAX_W{1'b1}} << w);
        din  = d & mask;
        fill = mask & ~(mask >> s);
        res  = din;
        case (op)
            SH_LSL:  res = (din << s) & mask;
            SH_LSR:  res = din >> s;
            SH_ASR:  res = (|(din >> (w - 1))) ? ((din >> s) | fill) : (din >> s);
            SH_ROR:  res = ((din >> s) | (din << (w - s))) & mask;
            default: res = din;
        endcase
        return res;
    endfunction

    // Set when a right shift by s discards any 1 bit from the bottom.
    function automatic logic shift_sticky(input wide_t d, input shift_op_t op, input int s);
        wide_t lost;
        lost = d & ~({c_MAX_W{1'b1}} << s);
        return ((op == SH_LSR) || (op == SH_ASR)) && (|lost);
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shift_stage.sv
// ============================================================================
// Module  : barrel_shift_stage
// Brief   : One log2 level of the barrel shifter: shift by 2**K, then a stall-capable register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W),
    parameter int K  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [W-1:0]  i_data,
    input  logic [SW-1:0] i_amt,
    input  shift_op_t     i_op,
`ifdef BARREL_SHIFT_STICKY_EN
    input  logic          i_sticky,
    output logic          o_sticky,
`endif
    input  logic          i_ready,
    output logic          o_valid,
    output logic [W-1:0]  o_data,
    output logic [SW-1:0] o_amt,
    output shift_op_t     o_op
);

    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [SW-1:0]    r_amt;
    shift_op_t        r_op;
    logic             w_load;
    logic [c_MAX_W-1:0] w_ext;
    logic [W-1:0]     w_data;

    always_comb begin
        w_ext        = '0;
        w_ext[W-1:0] = i_data;
        w_data       = i_data;
        if (i_amt[K]) begin
            w_data = W'(shift_level(w_ext, i_op, W, 1 << K));
        end
    end

    // Empty stages load even when downstream stalls, so bubbles collapse.
    assign w_load  = ~r_valid | i_ready;
    assign o_ready = w_load;

`ifdef BARREL_SHIFT_STICKY_EN
    logic r_sticky;
    logic w_sticky;

    assign w_sticky = i_sticky | (i_amt[K] & shift_sticky(w_ext, i_op, 1 << K));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_load && i_valid) begin
            r_sticky <= w_sticky;
        end
    end

    assign o_sticky = r_sticky;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_op    <= SH_LSL;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_data;
                r_amt  <= i_amt;
                r_op   <= i_op;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;
    assign o_op    = r_op;

endmodule

`default_nettype wire

// File: rtl/barrel_shift_pipelined.sv
// ============================================================================
// Module  : barrel_shift_pipelined
// Brief   : Pipelined barrel shifter (LSL/LSR/ASR/ROR), one registered level per amount bit,
//           valid/ready with backpressure. Define BARREL_SHIFT_STICKY_EN for down_sticky.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shift_pipelined
    import barrel_shift_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [W-1:0]  up_data,
    input  logic [SW-1:0] up_amt,
    input  logic [1:0]    up_op,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [W-1:0]  down_data
`ifdef BARREL_SHIFT_STICKY_EN
    ,
    output logic          down_sticky
`endif
);

    // Index k is the input of stage k; index SW is the output side.
    logic          w_valid [SW+1];
    logic          w_ready [SW+1];
    logic [W-1:0]  w_data  [SW+1];
    logic [SW-1:0] w_amt   [SW+1];
    shift_op_t     w_op    [SW+1];
`ifdef BARREL_SHIFT_STICKY_EN
    logic          w_sticky [SW+1];

    assign w_sticky[0] = 1'b0;
    assign down_sticky = w_sticky[SW];
`endif

    assign w_valid[0]  = up_valid;
    assign w_data[0]   = up_data;
    assign w_amt[0]    = up_amt;
    assign w_op[0]     = shift_op_t'(up_op);
    assign w_ready[SW] = down_ready;

    assign up_ready   = w_ready[0];
    assign down_valid = w_valid[SW];
    assign down_data  = w_data[SW];

    generate
        for (genvar k = 0; k < SW; k++) begin : g_stage
            barrel_shift_stage #(
                .W  (W),
                .SW (SW),
                .K  (k)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_valid  (w_valid[k]),
                .o_ready  (w_ready[k]),
                .i_data   (w_data[k]),
                .i_amt    (w_amt[k]),
                .i_op     (w_op[k]),
`ifdef BARREL_SHIFT_STICKY_EN
                .i_sticky (w_sticky[k]),
                .o_sticky (w_sticky[k+1]),
`endif
                .i_ready  (w_ready[k+1]),
                .o_valid  (w_valid[k+1]),
                .o_data   (w_data[k+1]),
                .o_amt    (w_amt[k+1]),
                .o_op     (w_op[k+1])
            );
        end
    endgenerate

endmodule

`default_nettype wire
